// File: rtl/named_value_pkg.sv
// Shared types and helpers for the named-value sum accumulator.
// Holds the opcode tags, FSM states and a width-generic saturating add.
package named_value_pkg;

    // Widest operand the saturating-add helper can handle.
    localparam int SAT_MW = 64;

    // Width of counters and the opcode field.
    localparam int CNT_W = 8;
    localparam int TAG_W = 8;

    typedef enum logic [TAG_W-1:0] {
        TAG_ACCUM = 8'd1,
        TAG_FLUSH = 8'd2
    } tag_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [SAT_MW:0] SAT_ONE = {{SAT_MW{1'b0}}, 1'b1};

    // Adds two w-bit values held in SAT_MW-bit containers.
    // Returns {overflow, clamped sum}; the sum clamps at 2^w-1.
    function automatic logic [SAT_MW:0] sat_add(
        input logic [SAT_MW-1:0] a,
        input logic [SAT_MW-1:0] b,
        input int unsigned       w
    );
        logic [SAT_MW:0] s;
        logic [SAT_MW:0] lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = (SAT_ONE << w) - SAT_ONE;
        if (s > lim) begin
            sat_add = {1'b1, lim[SAT_MW-1:0]};
        end else begin
            sat_add = {1'b0, s[SAT_MW-1:0]};
        end
    endfunction

endpackage

// File: rtl/named_value_sat_adder.sv
// Combinational W-bit saturating adder with overflow flag.
// Used for the window accumulator and the error counter.
module named_value_sat_adder
    import named_value_pkg::*;
#(
    parameter int W = 20
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         ovf_o
);

    // High bits of the helper result are always zero after clamping.
    logic [SAT_MW-W-1:0] hi_unused;

    // Widen both operands, add, and clamp at the W-bit maximum.
    always_comb begin
        {ovf_o, hi_unused, sum_o} = sat_add(SAT_MW'(a_i), SAT_MW'(b_i), W);
    end

endmodule

// File: rtl/named_value_sum_accumulator.sv
// Windowed, saturating accumulator for the named-value sum stream.
// Emits one registered total per full window or flush.
module named_value_sum_accumulator
    import named_value_pkg::*;
#(
    parameter int WINDOW = 4,
    parameter int SUM_W  = 16,
    parameter int ACC_W  = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUM_W-1:0] in_sum,
    input  logic [7:0]       in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_total,
    output logic [7:0]       out_count,
    output logic             out_overflow,
    output logic [7:0]       err_count
);

    localparam logic [CNT_W-1:0] WIN_CNT = CNT_W'(WINDOW);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               rdy_q, rdy_d;
    logic               vld_q, vld_d;
    logic [ACC_W-1:0]   total_q, total_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               oflow_q, oflow_d;
    logic [CNT_W-1:0]   err_q, err_d;

    logic [ACC_W-1:0]   sum_ext;
    logic [ACC_W-1:0]   acc_sum;
    logic               acc_ovf;
    logic               ovf_new;
    logic [CNT_W-1:0]   cnt_inc;
    logic [CNT_W-1:0]   err_sum;
    logic               err_ovf;
    logic               accept;
    logic               is_accum;
    logic               is_flush;

    assign sum_ext = ACC_W'(in_sum);

    named_value_sat_adder #(.W(ACC_W)) u_acc_add (
        .a_i   (acc_q),
        .b_i   (sum_ext),
        .sum_o (acc_sum),
        .ovf_o (acc_ovf)
    );

    named_value_sat_adder #(.W(CNT_W)) u_err_add (
        .a_i   (err_q),
        .b_i   (CNT_W'(1)),
        .sum_o (err_sum),
        .ovf_o (err_ovf)
    );

    // Decode the handshake and the opcode of the offered sample.
    always_comb begin
        accept   = in_valid && rdy_q;
        is_accum = (in_tag == TAG_ACCUM);
        is_flush = (in_tag == TAG_FLUSH);
        cnt_inc  = cnt_q + CNT_W'(1);
        ovf_new  = ovf_q | acc_ovf;
    end

    // Next-state, accumulator and result-register update.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        vld_d   = vld_q;
        total_d = total_q;
        count_d = count_q;
        oflow_d = oflow_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    if (is_accum) begin
                        acc_d   = acc_sum;
                        cnt_d   = cnt_inc;
                        ovf_d   = ovf_new;
                        state_d = ACCUM;
                        if (cnt_inc == WIN_CNT) begin
                            total_d = acc_sum;
                            count_d = cnt_inc;
                            oflow_d = ovf_new;
                            vld_d   = 1'b1;
                            state_d = HOLD;
                        end
                    end else if (is_flush) begin
                        vld_d   = 1'b1;
                        state_d = HOLD;
                        if (state_q == IDLE) begin
                            total_d = '0;
                            count_d = '0;
                            oflow_d = 1'b0;
                        end else begin
                            acc_d   = acc_sum;
                            cnt_d   = cnt_inc;
                            ovf_d   = ovf_new;
                            total_d = acc_sum;
                            count_d = cnt_inc;
                            oflow_d = ovf_new;
                        end
                    end else begin
                        err_d = err_ovf ? '1 : err_sum;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    vld_d   = 1'b0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        rdy_d = (state_d != HOLD);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
            total_q <= '0;
            count_q <= '0;
            oflow_q <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            rdy_q   <= rdy_d;
            vld_q   <= vld_d;
            total_q <= total_d;
            count_q <= count_d;
            oflow_q <= oflow_d;
            err_q   <= err_d;
        end
    end

    assign in_ready     = rdy_q;
    assign out_valid    = vld_q;
    assign out_total    = total_q;
    assign out_count    = count_q;
    assign out_overflow = oflow_q;
    assign err_count    = err_q;

endmodule

// File: tb/tb_named_value_sum_accumulator.sv
// Bench for named_value_sum_accumulator at WINDOW = 4, 32 and 1.
// Directed plan steps followed by random traffic against a window model.
module tb_named_value_sum_accumulator;

    localparam longint MAXV = (64'd1 << 20) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] in_sum;
    logic [7:0]  in_tag;

    logic        rdy [3];
    logic        vld [3];
    logic        ovf [3];
    logic [19:0] tot [3];
    logic [7:0]  cnt [3];
    logic [7:0]  err [3];

    int n_vec = 0;
    int n_bad = 0;

    longint m_acc [3];
    int     m_n   [3];
    bit     m_hold[3];
    bit     m_rdy [3];
    bit     m_vld [3];
    longint m_tot [3];
    int     m_cnt [3];
    bit     m_ovf [3];
    int     m_err [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        named_value_sum_accumulator #(
            .WINDOW(g == 0 ? 4 : (g == 1 ? 32 : 1)),
            .SUM_W (16),
            .ACC_W (20)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .in_valid    (in_valid),
            .in_ready    (rdy[g]),
            .in_sum      (in_sum),
            .in_tag      (in_tag),
            .out_valid   (vld[g]),
            .out_ready   (out_ready),
            .out_total   (tot[g]),
            .out_count   (cnt[g]),
            .out_overflow(ovf[g]),
            .err_count   (err[g])
        );
    end

    function automatic int win(input int i);
        return (i == 0) ? 4 : ((i == 1) ? 32 : 1);
    endfunction

    task automatic chk(input string name, input int i,
                       input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s[W=%0d] observed=%0h expected=%0h",
                   name, win(i), obs, exp);
        end
    endtask

    // Result of a finished window: plain sum clamped to 2^20-1.
    task automatic complete(input int i);
        m_tot[i]  = (m_acc[i] > MAXV) ? MAXV : m_acc[i];
        m_ovf[i]  = (m_acc[i] > MAXV);
        m_cnt[i]  = m_n[i];
        m_vld[i]  = 1'b1;
        m_hold[i] = 1'b1;
    endtask

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_acc[i] = 0;  m_n[i] = 0;   m_hold[i] = 0;
                m_rdy[i] = 0;  m_vld[i] = 0; m_tot[i] = 0;
                m_cnt[i] = 0;  m_ovf[i] = 0; m_err[i] = 0;
            end else begin
                if (m_hold[i]) begin
                    if (out_ready) begin
                        m_hold[i] = 0; m_vld[i] = 0;
                        m_acc[i]  = 0; m_n[i]   = 0;
                    end
                end else if (in_valid && m_rdy[i]) begin
                    if (in_tag == 8'd1) begin
                        m_acc[i] += longint'(in_sum);
                        m_n[i]++;
                        if (m_n[i] == win(i)) complete(i);
                    end else if (in_tag == 8'd2) begin
                        if (m_n[i] != 0) begin
                            m_acc[i] += longint'(in_sum);
                            m_n[i]++;
                        end
                        complete(i);
                    end else if (m_err[i] < 255) begin
                        m_err[i]++;
                    end
                end
                m_rdy[i] = !m_hold[i];
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk("in_ready",     i, 32'(rdy[i]), 32'(m_rdy[i]));
            chk("out_valid",    i, 32'(vld[i]), 32'(m_vld[i]));
            chk("out_total",    i, 32'(tot[i]), 32'(m_tot[i]));
            chk("out_count",    i, 32'(cnt[i]), 32'(m_cnt[i]));
            chk("out_overflow", i, 32'(ovf[i]), 32'(m_ovf[i]));
            chk("err_count",    i, 32'(err[i]), 32'(m_err[i]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic send(input int s, input int t);
        in_valid = 1'b1;
        in_sum   = 16'(s);
        in_tag   = 8'(t);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        tick();
        chk("rst.in_ready",  0, 32'(rdy[0]), 32'd0);
        chk("rst.out_valid", 0, 32'(vld[0]), 32'd0);
        chk("rst.err_count", 0, 32'(err[0]), 32'd0);
        rst = 1'b0;
        tick();
        chk("rst.ready_after", 0, 32'(rdy[0]), 32'd1);
    endtask

    initial begin
        int t;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sum    = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m_acc[i] = 0; m_n[i] = 0; m_hold[i] = 0; m_rdy[i] = 0;
            m_vld[i] = 0; m_tot[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
            m_err[i] = 0;
        end

        // Plan 1: full window of four.
        do_reset();
        send(100, 1);
        send(200, 1);
        send(300, 1);
        chk("t1.valid_early", 0, 32'(vld[0]), 32'd0);
        send(400, 1);
        chk("t1.valid", 0, 32'(vld[0]), 32'd1);
        chk("t1.total", 0, 32'(tot[0]), 32'd1000);
        chk("t1.count", 0, 32'(cnt[0]), 32'd4);
        chk("t1.ovf",   0, 32'(ovf[0]), 32'd0);
        idle(1);
        chk("t1.valid_drop", 0, 32'(vld[0]), 32'd0);

        // Plan 2: flush mid-window and from idle.
        send(7, 1);
        send(9, 2);
        chk("t2.total", 0, 32'(tot[0]), 32'd16);
        chk("t2.count", 0, 32'(cnt[0]), 32'd2);
        idle(1);
        send(5, 2);
        chk("t2.empty_valid", 0, 32'(vld[0]), 32'd1);
        chk("t2.empty_total", 0, 32'(tot[0]), 32'd0);
        chk("t2.empty_count", 0, 32'(cnt[0]), 32'd0);
        idle(1);

        // Plan 3: saturation with the 32-sample window.
        do_reset();
        repeat (17) send(16'hFFFF, 1);
        send(1, 2);
        chk("t3.total", 1, 32'(tot[1]), 32'hFFFFF);
        chk("t3.ovf",   1, 32'(ovf[1]), 32'd1);
        chk("t3.count", 1, 32'(cnt[1]), 32'd18);
        idle(1);
        send(3, 1);
        send(4, 2);
        chk("t3.next_ovf",   1, 32'(ovf[1]), 32'd0);
        chk("t3.next_total", 1, 32'(tot[1]), 32'd7);
        idle(1);

        // Plan 4: backpressure holds the result.
        do_reset();
        out_ready = 1'b0;
        send(1, 1);
        send(2, 1);
        send(3, 1);
        send(4, 1);
        in_valid = 1'b1;
        in_sum   = 16'd42;
        in_tag   = 8'd1;
        repeat (5) begin
            tick();
            chk("t4.hold_valid", 0, 32'(vld[0]), 32'd1);
            chk("t4.hold_total", 0, 32'(tot[0]), 32'd10);
            chk("t4.hold_ready", 0, 32'(rdy[0]), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("t4.release_ready", 0, 32'(rdy[0]), 32'd1);
        chk("t4.release_valid", 0, 32'(vld[0]), 32'd0);
        send(42, 1);
        send(0, 2);
        chk("t4.next_total", 0, 32'(tot[0]), 32'd42);
        chk("t4.next_count", 0, 32'(cnt[0]), 32'd2);
        idle(1);

        // Plan 5: illegal tags are counted and dropped.
        do_reset();
        send(10, 1);
        send(50, 3);
        send(20, 1);
        send(0, 2);
        chk("t5.total", 0, 32'(tot[0]), 32'd30);
        chk("t5.count", 0, 32'(cnt[0]), 32'd3);
        chk("t5.err",   0, 32'(err[0]), 32'd1);
        idle(1);
        repeat (300) begin
            t = int'($urandom_range(0, 253));
            if (t >= 1) t += 2;
            send(int'($urandom_range(0, 65535)), t);
        end
        chk("t5.err_sat", 0, 32'(err[0]), 32'd255);

        // Plan 6: reset mid-window discards the partial sum.
        send(1, 1);
        send(1, 1);
        do_reset();
        repeat (4) send(1, 1);
        chk("t6.total", 0, 32'(tot[0]), 32'd4);
        chk("t6.count", 0, 32'(cnt[0]), 32'd4);
        chk("t6.err",   0, 32'(err[0]), 32'd0);
        idle(1);

        // Random traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            rst      = ($urandom_range(0, 99) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            t        = int'($urandom_range(0, 19));
            if (t < 14)      in_tag = 8'd1;
            else if (t < 18) in_tag = 8'd2;
            else             in_tag = 8'($urandom_range(3, 255));
            if ($urandom_range(0, 3) == 0) in_sum = 16'hFFFF;
            else                           in_sum = 16'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        rst      = 1'b0;
        in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
